// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, single-step shift in either
// direction, and a burst engine that performs a programmed number of shifts
// with a busy/done handshake.
// Optional feature macro: ROTATE_SHIFT_EN adds a 'rotate' input that feeds
// the outgoing bit back in place of serial_in on every shift.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             serial_in,
`ifdef ROTATE_SHIFT_EN
  input  logic             rotate,
`endif
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  // Burst handshake: burst_start is a one-cycle request taken only while
  // busy=0. busy rises the cycle after acceptance and stays high for exactly
  // burst_len cycles; done pulses for one cycle after the last shift (or the
  // cycle after a zero-length request). done and busy are never high together,
  // and commands presented while busy=1 are dropped.
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  logic               eff_dir;
  logic               out_bit;
  logic               shift_bit;
  logic [WIDTH-1:0]   shifted;
  logic [CNT_W-1:0]   len_clamped;

  // Shift datapath: direction is latched during a burst, live while idle.
  always_comb begin
    eff_dir = (state_q == BURST) ? dir_q : dir;
    out_bit = eff_dir ? data_q[0] : data_q[WIDTH-1];
`ifdef ROTATE_SHIFT_EN
    shift_bit = rotate ? out_bit : serial_in;
`else
    shift_bit = serial_in;
`endif
    shifted = eff_dir ? {shift_bit, data_q[WIDTH-1:1]}
                      : {data_q[WIDTH-2:0], shift_bit};
    len_clamped = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;
  end

  // Next-state and next-datapath logic; in IDLE load beats burst_start beats shift_en.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = load_data;
        end else if (burst_start) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            cnt_d   = len_clamped;
            dir_d   = dir;
          end
        end else if (shift_en) begin
          data_d = shifted;
        end
      end
      BURST: begin
        data_d = shifted;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, burst counter, latched direction and done pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  assign data_out   = data_q;
  assign serial_out = out_bit;
  assign busy       = (state_q == BURST);
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8): reset, table of single-cycle
// load/shift vectors, and hand-written burst sequences.
module tb_universal_shift_reg;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [W-1:0]  load_data;
  logic          shift_en;
  logic          dir;
  logic          serial_in;
  logic          rotate;
  logic          burst_start;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;
  logic          state_dbg;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .load_data(load_data),
    .shift_en(shift_en),
    .dir(dir),
    .serial_in(serial_in),
`ifdef ROTATE_SHIFT_EN
    .rotate(rotate),
`endif
    .burst_start(burst_start),
    .burst_len(burst_len),
    .data_out(data_out),
    .serial_out(serial_out),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] ld_data;
    logic         sh;
    logic         dr;
    logic         sin;
    logic         exp_so;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; load_data = '0; shift_en = 1'b0; dir = 1'b0;
    serial_in = 1'b0; rotate = 1'b0; burst_start = 1'b0; burst_len = '0;
  endtask

  // Scoreboard: push expectation with the stimulus, pop once the edge has acted.
  task automatic sb_step(input string name, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    step();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (data_out !== e) begin
        failures++;
        $display("FAIL %s: data_out got 0x%0h expected 0x%0h", name, data_out, e);
      end
    end
  endtask

  int busy_cnt;
  logic saw_done;
  logic [W-1:0] rot_exp[8];

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4B};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h97};
    vecs[3] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h52};
    vecs[5] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h9E};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h9E};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};

    rot_exp[0] = 8'h81; rot_exp[1] = 8'hC0; rot_exp[2] = 8'h60; rot_exp[3] = 8'h30;
    rot_exp[4] = 8'h18; rot_exp[5] = 8'h0C; rot_exp[6] = 8'h06; rot_exp[7] = 8'h03;

    // Reset with random inputs
    idle_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load = 1'($urandom_range(0, 1)); load_data = 8'($urandom_range(0, 255));
      shift_en = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
      serial_in = 1'($urandom_range(0, 1)); burst_start = 1'($urandom_range(0, 1));
      burst_len = 4'($urandom_range(0, 15));
      step();
      check("rst_data", 32'(data_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_so", 32'(serial_out), 32'h0);
    end
    idle_inputs();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_step("idle_data", 8'h00);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_done", 32'(done), 32'h0);
    end

    // Table-driven load / single-step shifts
    for (int i = 0; i < 9; i++) begin
      load = vecs[i].ld; load_data = vecs[i].ld_data; shift_en = vecs[i].sh;
      dir = vecs[i].dr; serial_in = vecs[i].sin;
      #1;
      check($sformatf("vec%0d_so", i), 32'(serial_out), 32'(vecs[i].exp_so));
      sb_step($sformatf("vec%0d", i), vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end
    idle_inputs();

    // Burst of 4 toward MSB; commands during busy must be dropped
    load = 1'b1; load_data = 8'hF0;
    sb_step("b4_load", 8'hF0);
    idle_inputs();
    burst_start = 1'b1; burst_len = 4'd4; dir = 1'b0; serial_in = 1'b0;
    sb_step("b4_start", 8'hF0);
    burst_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b4_busy%0d", k), 32'(busy), 32'h1);
      check($sformatf("b4_done%0d", k), 32'(done), 32'h0);
      dir = 1'b1;  // live dir flips; latched dir must still be used
      load = k[0]; load_data = 8'hFF; shift_en = ~k[0]; burst_start = k[1];
      #1;
      check($sformatf("b4_so%0d", k), 32'(serial_out), 32'h1);
      sb_step($sformatf("b4_shift%0d", k), 8'(8'hF0 << (k + 1)));
    end
    idle_inputs();
    check("b4_end_busy", 32'(busy), 32'h0);
    check("b4_end_done", 32'(done), 32'h1);
    sb_step("b4_after", 8'h00);
    check("b4_done_clear", 32'(done), 32'h0);

    // Zero-length burst
    load = 1'b1; load_data = 8'h5A;
    sb_step("z_load", 8'h5A);
    idle_inputs();
    burst_start = 1'b1; burst_len = 4'd0;
    sb_step("z_start", 8'h5A);
    burst_start = 1'b0;
    check("z_done", 32'(done), 32'h1);
    check("z_busy", 32'(busy), 32'h0);
    sb_step("z_after", 8'h5A);
    check("z_done_clear", 32'(done), 32'h0);
    check("z_busy2", 32'(busy), 32'h0);

    // Over-length burst clamps to WIDTH shifts toward LSB
    burst_start = 1'b1; burst_len = 4'd12; dir = 1'b1; serial_in = 1'b1;
    sb_step("cl_start", 8'h5A);
    burst_start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (busy) busy_cnt++;
      step();
    end
    check("cl_done", 32'(done), 32'h1);
    check("cl_busy_cycles", 32'(busy_cnt), 32'd8);
    check("cl_data", 32'(data_out), 32'hFF);
    idle_inputs();
    step();

    // Reset mid-burst aborts without done
    burst_start = 1'b1; burst_len = 4'd8;
    step();
    burst_start = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("ab_data", 32'(data_out), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_done", 32'(done), 32'h0);
    step();
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) saw_done = 1'b1;
      sb_step("ab_idle", 8'h00);
    end
    check("ab_no_done", 32'(saw_done), 32'h0);

    // Fresh burst of 2 after the abort
    burst_start = 1'b1; burst_len = 4'd2; dir = 1'b0; serial_in = 1'b1;
    sb_step("f_start", 8'h00);
    burst_start = 1'b0;
    check("f_busy0", 32'(busy), 32'h1);
    sb_step("f_shift0", 8'h01);
    check("f_busy1", 32'(busy), 32'h1);
    sb_step("f_shift1", 8'h03);
    check("f_busy_end", 32'(busy), 32'h0);
    check("f_done", 32'(done), 32'h1);
    idle_inputs();
    step();

`ifdef ROTATE_SHIFT_EN
    // Rotate on single step and across a full-width burst
    load = 1'b1; load_data = 8'h81;
    sb_step("r_load", 8'h81);
    idle_inputs();
    rotate = 1'b1; shift_en = 1'b1; dir = 1'b0; serial_in = 1'b0;
    sb_step("r_step", 8'h03);
    shift_en = 1'b0;
    burst_start = 1'b1; burst_len = 4'd8; dir = 1'b1;
    sb_step("r_start", 8'h03);
    burst_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sb_step($sformatf("r_burst%0d", k), rot_exp[k]);
    end
    check("r_done", 32'(done), 32'h1);
    idle_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register with parallel load, bidirectional serial shift and an autonomous burst-shift engine.
- Burst engine shifts a programmed number of bits with busy/done handshake.
- Serves as the generic serialiser/deserialiser primitive for lab datapaths, replacing fixed 4-bit shift-left registers.

Parameters:
WIDTH, 8, register width in bits (≥2)
CNT_W, $clog2(WIDTH+1), burst counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  reset, asynchronous, active-low
load  in  1  parallel load strobe
load_data  in  WIDTH  parallel load value
shift_en  in  1  single-step shift enable
dir  in  1  0 = shift toward MSB (serial_in enters bit 0); 1 = toward LSB (serial_in enters bit WIDTH-1)
serial_in  in  1  serial data input
burst_start  in  1  start burst shift (single-cycle strobe)
burst_len  in  CNT_W  number of shifts in burst, 0..WIDTH
data_out  out  WIDTH  register contents
serial_out  out  1  bit leaving on next shift
busy  out  1  burst in progress
done  out  1  one-cycle burst completion pulse

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low.
- Reset values: data_out=0, busy=0, done=0, state IDLE, counter=0, latched direction=0.
- States: IDLE, BURST.
- IDLE priority, highest first, one action per cycle: load > burst_start > shift_en.
  - load: data_out <= load_data next edge.
  - shift_en: one shift per edge using current dir.
    - dir=0: data_out <= {data_out[WIDTH-2:0], serial_in}.
    - dir=1: data_out <= {serial_in, data_out[WIDTH-1:1]}.
  - burst_start with burst_len=L>0: latch dir and L; go to BURST.
  - busy is 1 from the next cycle.
  - burst_start with L=0: stay IDLE, no shift; done=1 for exactly the next cycle; busy never asserts.
- BURST:
  - One shift per cycle using the latched dir and live serial_in; counter decrements.
  - The edge performing shift L returns to IDLE: busy=0 and done=1 for one cycle after that edge.
  - Exactly L shifts occur, so busy is high for exactly L cycles.
  - load, shift_en and burst_start are ignored (dropped, not queued) while busy=1.
- burst_len > WIDTH: clamped to WIDTH.
- serial_out is combinational from the register and the effective direction (latched dir in BURST, dir input in IDLE):
  - dir=0: data_out[WIDTH-1].
  - dir=1: data_out[0].
- done is registered and never asserts together with busy.
- done may coincide with new IDLE commands, which are accepted that cycle.
- reset_n asserted mid-burst: immediate abort, all reset values, no done pulse.

Optional Feature:
ROTATE_SHIFT_EN
- Defined: adds input port rotate (1 bit), sampled on every shift (single-step, and each burst cycle).
  - When rotate=1, the bit shifted out is fed back in place of serial_in.
  - dir=0: {q[WIDTH-2:0], q[WIDTH-1]}. dir=1: {q[0], q[WIDTH-1:1]}.
- Undefined: port absent; serial_in always used.

Test Plan:
- Assert reset_n low with random inputs -> data_out=0x00, busy=0, done=0, serial_out=0; release, hold all inputs idle 5 cycles -> unchanged.
- WIDTH=8: load 0xA5; shift_en, dir=0, serial_in=1 for 2 cycles -> 0x4B then 0x97; serial_out = 1 before first shift, 0 before second.
- Load 0xA5; shift_en, dir=1, serial_in=0 one cycle -> 0x52; serial_out=1 before the shift. load and shift_en high together with load_data=0x3C -> 0x3C (load wins).
- Load 0xF0; burst_start, len=4, dir=0, serial_in=0 -> busy=1 for 4 cycles, serial_out 1,1,1,1, data_out=0x00, done=1 one cycle. load=0xFF and shift_en pulses during busy -> ignored.
- burst_start, len=0 -> done=1 next cycle, busy stays 0, data unchanged. burst_start, len=8 then reset_n low on cycle 3 -> all zero, no done; a fresh len=2 burst completes normally.
- ROTATE_SHIFT_EN: load 0x81; rotate=1, dir=0, one shift -> 0x03. Burst len=8 with dir=1, rotate=1 -> 0x03 restored, done pulse.
